// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: reader side of a multiplexed 7-segment display.
// Samples the active-low anodes and the segment bus. A pair is committed once it
// has stayed stable for STABLE edges. It is then decoded back into the digit
// register of the selected position, and a one-cycle update pulse is raised.
module seg7_scan_decoder #(
    parameter int NDIG   = 2,
    parameter int STABLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           seg_in,
    input  logic [NDIG-1:0]      an_in,
    output logic [4*NDIG-1:0]    digits_out,
    output logic [NDIG-1:0]      valid_out,
    output logic                 upd,
    output logic [2:0]           upd_idx,
    output logic                 err
);

    localparam logic [7:0] LP_STABLE = 8'(STABLE);

    logic [NDIG-1:0]   r_cap_an;
    logic [6:0]        r_cap_seg;
    logic [7:0]        r_cnt;
    logic [4*NDIG-1:0] r_digits;
    logic [NDIG-1:0]   r_valid;
    logic              r_upd;
    logic [2:0]        r_upd_idx;
    logic              r_err;

    logic [3:0]        w_zeros;
    logic [2:0]        w_idx;
    logic              w_sel;
    logic              w_same;
    logic [7:0]        w_cnt_nxt;
    logic              w_commit;
    logic              w_legal;
    logic [3:0]        w_value;

    // Count low anodes and remember which one is low; exactly one means selecting.
    always_comb begin
        w_zeros = 4'd0;
        w_idx   = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (!an_in[i]) begin
                w_zeros = w_zeros + 4'd1;
                w_idx   = 3'(i);
            end
        end
        w_sel = (w_zeros == 4'd1);
    end

    // Stability counter next value. A commit happens only on the edge that
    // brings the count to STABLE, so a pair held at saturation never re-commits.
    always_comb begin
        w_same    = ({an_in, seg_in} == {r_cap_an, r_cap_seg});
        w_cnt_nxt = 8'd0;
        if (w_sel) begin
            if (!w_same)
                w_cnt_nxt = 8'd1;
            else if (r_cnt < LP_STABLE)
                w_cnt_nxt = r_cnt + 8'd1;
            else
                w_cnt_nxt = r_cnt;
        end
        w_commit = w_sel && (w_cnt_nxt == LP_STABLE) &&
                   !(w_same && (r_cnt == LP_STABLE));
    end

    // Segment pattern to digit decode; all-dark is a legal blank (F).
    always_comb begin
        w_legal = 1'b1;
        w_value = 4'hF;
        case (seg_in)
            7'h3F:   w_value = 4'h0;
            7'h06:   w_value = 4'h1;
            7'h5B:   w_value = 4'h2;
            7'h4F:   w_value = 4'h3;
            7'h66:   w_value = 4'h4;
            7'h6D:   w_value = 4'h5;
            7'h7D:   w_value = 4'h6;
            7'h07:   w_value = 4'h7;
            7'h7F:   w_value = 4'h8;
            7'h6F:   w_value = 4'h9;
            7'h00:   w_value = 4'hF;
            default: w_legal = 1'b0;
        endcase
    end

    // Capture registers and stability counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cap_an  <= '0;
            r_cap_seg <= '0;
            r_cnt     <= 8'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_sel && !w_same) begin
                r_cap_an  <= an_in;
                r_cap_seg <= seg_in;
            end
        end
    end

    // Commit: update only the selected position and pulse upd/err for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits  <= '0;
            r_valid   <= '0;
            r_upd     <= 1'b0;
            r_upd_idx <= 3'd0;
            r_err     <= 1'b0;
        end else begin
            r_upd <= w_commit;
            r_err <= w_commit && !w_legal;
            if (w_commit)
                r_upd_idx <= w_idx;
            for (int i = 0; i < NDIG; i++) begin
                if (w_commit && (w_idx == 3'(i))) begin
                    r_valid[i] <= w_legal;
                    if (w_legal)
                        r_digits[4*i +: 4] <= w_value;
                end
            end
        end
    end

    assign digits_out = r_digits;
    assign valid_out  = r_valid;
    assign upd        = r_upd;
    assign upd_idx    = r_upd_idx;
    assign err        = r_err;

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Reader side of the multiplexed 7-segment display interface. Samples the segment bus and the active-low digit anodes and rejects transient or ghost patterns.
- Decodes each stable pattern back to a 4-bit digit value and holds one digit register per display position.
- Used as a loopback monitor on the traffic-signal countdown display and as a front end for display self-test.

Parameters:
- NDIG, 2, number of multiplexed digit positions (1..8).
- STABLE, 4, number of consecutive clock edges an (anode, segment) pair must persist before it is committed (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment bus, active-high; bit6..bit0 = g,f,e,d,c,b,a.
- an_in  input  NDIG  digit anodes, active-low, one-hot-low when driving.
- digits_out  output  4*NDIG  digit i at bits [4i+3:4i]; 4'hF means blank.
- valid_out  output  NDIG  bit i set when digit i holds a legally decoded pattern.
- upd  output  1  one-cycle pulse when a position is committed (legal or illegal).
- upd_idx  output  3  index of the committed position; meaningful only while upd=1.
- err  output  1  one-cycle pulse, coincident with upd, on an illegal pattern.

Behaviour:
- Reset (async, immediate):
  - digits_out=0, valid_out=0, upd=0, upd_idx=0, err=0.
  - Internal pattern/anode capture registers and the stability counter are cleared.
- Selection: the input is "selecting" only when exactly one bit of an_in is 0. All-ones, or two or more zeros, counts as not selecting.
- Stability counter (cnt, 8 bits, saturating at STABLE):
  - Each edge, if selecting and {an_in, seg_in} equals the captured pair: cnt increments, up to STABLE.
  - If selecting and the pair differs from the captured pair: capture the new pair, cnt=1.
  - If not selecting: cnt=0.
- Commit: occurs on the edge where cnt becomes STABLE, i.e. the pair has been present at STABLE consecutive edges.
  - Outputs update at that edge, so latency is STABLE edges from when the pair is first applied.
  - With STABLE=1, commit occurs at the first edge of a new pair.
  - While the pair is held at saturation there is no further commit. A change and return of the pair commits again.
- Decode table (seg value -> digit):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
  - 00->F (blank, legal).
  - Any other value is illegal.
- Legal commit at position i:
  - digits_out[i]=decoded value, valid_out[i]=1.
  - upd=1, upd_idx=i, err=0.
- Illegal commit at position i:
  - digits_out[i] unchanged, valid_out[i]=0.
  - upd=1, upd_idx=i, err=1.
- upd and err are high for exactly one cycle and 0 otherwise. Other positions are never disturbed by a commit.
- Glitch rejection: any pair change or non-selecting cycle before cnt reaches STABLE discards the partial count. No output changes.
- Reset asserted mid-count aborts the count. After release, a pair still held needs a full STABLE edges to commit.

Test Plan:
- Reset release, STABLE=4, an_in=2'b10, seg_in=7'h5B held -> upd=1, upd_idx=0 after the 4th edge; digits_out[3:0]=2, valid_out=2'b01; no second upd over 10 more cycles.
- Alternate positions every 8 cycles: an_in=2'b01/seg 7'h6F, then an_in=2'b10/seg 7'h07 -> digits_out=8'h97, valid_out=2'b11, one upd per position change.
- seg_in=7'h4F held only 3 edges, then changed to 7'h66 held 4 edges on position 0 -> single commit, digit 4; the value 3 never appears.
- an_in=2'b00 (ghost) or 2'b11 for 20 cycles with seg 7'h3F -> no upd; outputs unchanged.
- Illegal seg_in=7'h12 held 4 edges on position 1, with that position previously 5 -> upd=1, err=1, upd_idx=1, digits_out[7:4] stays 5, valid_out[1]=0. Then 7'h00 -> digit F, valid_out[1]=1.
- rst pulsed after 2 of 4 stable edges -> outputs zero at once; with the pair still held, commit happens exactly 4 edges after rst deasserts.
